bnn_dense_engine: RTL
=====================

// Module: bnn_dense_engine
// PURPOSE
//  Parametrised binary fully-connected layer for the MNIST BNN datapath.
//  Computes XNOR-popcount of one latched input vector against OUT_NEURONS
//  weight rows, PAR neurons per cycle, with a start/busy/done handshake.
//  Produces thresholded activation bits, and optionally a running argmax class.
//  Generalises the fixed final layer so hidden and output layers share one engine.
// PARAMETERS
//  IN_BITS     196                    input vector width (bits per weight row)
//  OUT_NEURONS 10                     neuron count
//  PAR         2                      neurons evaluated per RUN cycle (1..OUT_NEURONS)
//  THRESH      IN_BITS/2              activation threshold: act=1 iff popcount>=THRESH
//  CNT_W       $clog2(IN_BITS+1)      popcount width (derived)
//  CLS_W       $clog2(OUT_NEURONS)    class index width (derived, min 1)
// PORTS
//  clk        in   1                   clock, rising edge
//  rst_n      in   1                   asynchronous active-low reset
//  start      in   1                   request; sampled only in IDLE
//  data_in    in   IN_BITS             input vector, latched on accepted start
//  weights_in in   OUT_NEURONS*IN_BITS row n = weights_in[n*IN_BITS +: IN_BITS]
//  busy       out  1                   high in RUN and DONE
//  done       out  1                   one-cycle completion pulse
//  act_out    out  OUT_NEURONS         activation bit per neuron
//  class_out  out  CLS_W               argmax neuron index
//  max_count  out  CNT_W               popcount of class_out neuron
// BEHAVIOUR
//  - Reset: state=IDLE; busy, done, act_out, class_out, max_count, group ctr,
//    data latch all 0.
//  - NGROUPS = ceil(OUT_NEURONS/PAR). States IDLE -> RUN -> DONE -> IDLE.
//  - IDLE: start=1 latches data_in, clears act_out, class_out, max_count,
//    group=0, -> RUN. start=0: hold; outputs keep last result.
//  - RUN: each cycle group g evaluates neurons g*PAR .. g*PAR+PAR-1;
//    pc = popcount(~(data_q ^ row_n)); act_out[n] <= (pc >= THRESH).
//    Lanes with index >= OUT_NEURONS (partial last group) are masked: no writes.
//    After group NGROUPS-1 -> DONE.
//  - DONE: done=1 for exactly one cycle, -> IDLE. act_out/class_out valid from
//    the done cycle until the next accepted start.
//  - Latency: start sampled at edge k -> done high in cycle after edge k+NGROUPS
//    (NGROUPS+1 cycles after start).
//  - start during RUN/DONE ignored (no queueing); start in the DONE->IDLE
//    cycle's following IDLE is accepted normally (back-to-back = NGROUPS+2 cycles).
//  - weights_in must stay stable from start until done; data_in is don't-care
//    after the start edge.
//  - popcount range 0..IN_BITS, no saturation needed at CNT_W.
//  - rst_n low mid-RUN: immediate return to IDLE, all outputs 0, no done pulse.
// CONFIGURATION
//  BNN_ARGMAX_EN defined: per RUN cycle, lanes compared in ascending index;
//    update max when pc > max_count (strict), so ties keep lowest index;
//    first evaluated neuron (index 0) always loads. class_out/max_count final at done.
//  BNN_ARGMAX_EN undefined: no comparator logic; class_out and max_count tied 0.
// TESTING (IN_BITS=8, OUT_NEURONS=4, PAR=2, THRESH=4, BNN_ARGMAX_EN on)
//  1 data=8'hF0, rows {r0..r3}={F0,0F,FF,F1}, pulse start -> pcs {8,0,4,7};
//    act_out=4'b1101, class_out=0, max_count=8.
//  2 Same run: busy high 3 cycles, done high exactly cycle 3 after start edge.
//  3 Tie: rows {0F,F0,F0,00}, data=F0 -> pcs {0,8,8,4}; class_out=1, act=4'b1110.
//  4 start held high through RUN -> only one done; second run starts after IDLE.
//  5 rst_n low on second RUN cycle -> busy=0, done never pulses, act_out=0.
//  6 PAR=3 build: NGROUPS=2, case 1 stimuli -> identical results, lanes 4,5 masked.

Source files
------------

// File: rtl/bnn_dense_engine_if.sv
// Handshake and data bus of the binary dense-layer engine.
// The master modport faces the requester and the slave modport faces the engine.
interface bnn_dense_engine_if #(
   parameter int IN_BITS     = 196,
   parameter int OUT_NEURONS = 10
);
   localparam int CNT_W = $clog2(IN_BITS + 1);
   localparam int CLS_W = (OUT_NEURONS > 1) ? $clog2(OUT_NEURONS) : 1;

   logic                           start;
   logic [IN_BITS-1:0]             data_in;
   logic [OUT_NEURONS*IN_BITS-1:0] weights_in;
   logic                           busy;
   logic                           done;
   logic [OUT_NEURONS-1:0]         act_out;
   logic [CLS_W-1:0]               class_out;
   logic [CNT_W-1:0]               max_count;

   modport master (
      output start, data_in, weights_in,
      input  busy, done, act_out, class_out, max_count
   );

   modport slave (
      input  start, data_in, weights_in,
      output busy, done, act_out, class_out, max_count
   );
endinterface

// File: rtl/bnn_dense_engine.sv
// Binary fully-connected layer: XNOR-popcount of a latched input against weight rows, PAR neurons per cycle.
// Optional running argmax over neurons is enabled by defining BNN_ARGMAX_EN.
module bnn_dense_engine #(
   parameter int IN_BITS     = 196,
   parameter int OUT_NEURONS = 10,
   parameter int PAR         = 2,
   parameter int THRESH      = IN_BITS / 2,
   localparam int CNT_W      = $clog2(IN_BITS + 1),
   localparam int CLS_W      = (OUT_NEURONS > 1) ? $clog2(OUT_NEURONS) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   bnn_dense_engine_if.slave   bus
);
   localparam int NGROUPS = (OUT_NEURONS + PAR - 1) / PAR;
   localparam int GRP_W   = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
   localparam int NPAD    = NGROUPS * PAR;
   localparam int IDX_W   = (NPAD > 1) ? $clog2(NPAD) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   function automatic logic [CNT_W-1:0] popcount(input logic [IN_BITS-1:0] v);
      logic [CNT_W-1:0] cnt;
      cnt = {CNT_W{1'b0}};
      for (int i = 0; i < IN_BITS; i++) begin
         cnt = cnt + CNT_W'(v[i]);
      end
      return cnt;
   endfunction

   state_e                 state_q, state_d;
   logic [GRP_W-1:0]       grp_q, grp_d;
   logic [IN_BITS-1:0]     data_q, data_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic [OUT_NEURONS-1:0] act_q, act_d;
`ifdef BNN_ARGMAX_EN
   logic [CLS_W-1:0]       class_q, class_d;
   logic [CNT_W-1:0]       max_q, max_d;
`endif

   logic [IN_BITS-1:0]     rows_s     [NPAD];
   int                     lane_n_s   [PAR];
   logic                   lane_vld_s [PAR];
   logic [IDX_W-1:0]       lane_idx_s [PAR];
   logic [CNT_W-1:0]       lane_pc_s  [PAR];

   // Unpack the weight bus into rows; padding rows of a partial last group read as zero.
   always_comb begin
      for (int r = 0; r < NPAD; r++) begin
         rows_s[r] = {IN_BITS{1'b0}};
      end
      for (int r = 0; r < OUT_NEURONS; r++) begin
         rows_s[r] = bus.weights_in[r*IN_BITS +: IN_BITS];
      end
   end

   // Per-lane neuron index, validity mask and XNOR popcount for the current group.
   always_comb begin
      for (int l = 0; l < PAR; l++) begin
         lane_n_s[l]   = int'(grp_q) * PAR + l;
         lane_vld_s[l] = (lane_n_s[l] < OUT_NEURONS);
         lane_idx_s[l] = IDX_W'(lane_n_s[l]);
         lane_pc_s[l]  = popcount(~(data_q ^ rows_s[lane_idx_s[l]]));
      end
   end

   // Next-state, datapath updates and registered-output values.
   always_comb begin
      state_d = state_q;
      grp_d   = grp_q;
      data_d  = data_q;
      act_d   = act_q;
`ifdef BNN_ARGMAX_EN
      class_d = class_q;
      max_d   = max_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d = S_RUN;
               grp_d   = {GRP_W{1'b0}};
               data_d  = bus.data_in;
               act_d   = {OUT_NEURONS{1'b0}};
`ifdef BNN_ARGMAX_EN
               class_d = {CLS_W{1'b0}};
               max_d   = {CNT_W{1'b0}};
`endif
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            for (int n = 0; n < OUT_NEURONS; n++) begin
               for (int l = 0; l < PAR; l++) begin
                  if (lane_vld_s[l] && (lane_n_s[l] == n)) begin
                     act_d[n] = (lane_pc_s[l] >= CNT_W'(THRESH));
                  end else begin
                     act_d[n] = act_d[n];
                  end
               end
            end
`ifdef BNN_ARGMAX_EN
            // Ascending lane order with strict compare keeps the lowest index on ties.
            for (int l = 0; l < PAR; l++) begin
               if (lane_vld_s[l] && ((lane_n_s[l] == 0) || (lane_pc_s[l] > max_d))) begin
                  max_d   = lane_pc_s[l];
                  class_d = CLS_W'(lane_n_s[l]);
               end else begin
                  max_d   = max_d;
               end
            end
`endif
            if (grp_q == GRP_W'(NGROUPS - 1)) begin
               state_d = S_DONE;
            end else begin
               grp_d = grp_q + GRP_W'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         grp_q   <= {GRP_W{1'b0}};
         data_q  <= {IN_BITS{1'b0}};
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         act_q   <= {OUT_NEURONS{1'b0}};
`ifdef BNN_ARGMAX_EN
         class_q <= {CLS_W{1'b0}};
         max_q   <= {CNT_W{1'b0}};
`endif
      end else begin
         state_q <= state_d;
         grp_q   <= grp_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         act_q   <= act_d;
`ifdef BNN_ARGMAX_EN
         class_q <= class_d;
         max_q   <= max_d;
`endif
      end
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.act_out = act_q;
`ifdef BNN_ARGMAX_EN
   assign bus.class_out = class_q;
   assign bus.max_count = max_q;
`else
   assign bus.class_out = {CLS_W{1'b0}};
   assign bus.max_count = {CNT_W{1'b0}};
`endif
endmodule
